// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to add the sgn port for two's-complement division.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
`ifdef DIV_SIGNED_EN
  ,
  input  logic             sgn
`endif
);
  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] dvd, rem, bd, dvd_n, rem_n, a_m, b_m;
  logic [WIDTH:0] rem_sh, diff;
  logic [CW-1:0] cnt;
  logic s, neg_q, neg_r, ge, last, go;
`ifdef DIV_SIGNED_EN
  assign s = sgn;
`else
  assign s = 1'b0;
`endif
  assign go  = (state == IDLE) && load;
  assign a_m = (s && a[WIDTH-1]) ? -a : a;
  assign b_m = (s && b[WIDTH-1]) ? -b : b;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE) ? (load ? ((b == '0) ? ZERO : RUN) : IDLE) :
              (state == RUN)  ? (last ? IDLE : RUN) : IDLE;
  // A borrow out of the WIDTH+1 bit subtraction means the shifted remainder is below the divisor.
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    diff   = rem_sh - {1'b0, bd};
    ge     = ~diff[WIDTH];
    rem_n  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_n  = {dvd[WIDTH-2:0], ge};
    last   = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dvd      <= '0;
      rem      <= '0;
      bd       <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        div_zero <= 1'b0;
        dvd      <= (b == '0) ? a : a_m;
        bd       <= b_m;
        rem      <= '0;
        cnt      <= '0;
        busy     <= b != '0;
        neg_q    <= s & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r    <= s & a[WIDTH-1];
      end else if (state == RUN) begin
        dvd <= dvd_n;
        rem <= rem_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          q    <= neg_q ? -dvd_n : dvd_n;
          r    <= neg_r ? -rem_n : rem_n;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end else if (state == ZERO) begin
        q        <= '1;
        r        <= dvd;
        div_zero <= 1'b1;
        done     <= 1'b1;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random divisions checked against an arithmetic reference model.
module tb_seq_divider;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0, sgn = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] q, r;
  logic busy, done, div_zero;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
`ifdef DIV_SIGNED_EN
    , .sgn(sgn)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                output logic [W-1:0] mq, output logic [W-1:0] mr);
    int sa, sb;
    if (mb == '0) begin
      mq = '1;
      mr = ma;
    end else if (ms) begin
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      mq = W'(sa / sb);
      mr = W'(sa % sb);
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
  endfunction
  // inj >= 0 raises a one-cycle a=1/b=1 load sampled on edge E(inj+1), which must be ignored.
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input int inj);
    logic [W-1:0] eq, er;
    int k, bad;
    model(ta, tb, ts, eq, er);
    @(negedge clk);
    a = ta; b = tb; sgn = ts; load = 1'b1;
    @(negedge clk);
    load = 1'b0; a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
    chk("busy_after_accept", busy, tb != '0);
    k = 0;
    bad = 0;
    while (k < 3 * W) begin
      if (k == inj) begin load = 1'b1; a = 1; b = 1; end
      @(negedge clk);
      k++;
      load = 1'b0;
      if (done) break;
      if (busy !== (tb != '0)) bad++;
    end
    chk("latency", k, (tb == '0) ? 1 : W);
    chk("busy_during_run", bad, 0);
    chk("busy_at_done", busy, 0);
    chk("q", q, eq);
    chk("r", r, er);
    chk("div_zero", div_zero, tb == '0);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("q_hold", q, eq);
    chk("r_hold", r, er);
  endtask
  initial begin
    logic [W-1:0] ra, rb;
    int pulses;
    #2;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    @(negedge clk);
    rst = 1'b1;
    run(16'd100, 16'd7, 1'b0, -1);
    run(16'd5, 16'd0, 1'b0, -1);
    run(16'd9, 16'd3, 1'b0, -1);
    run(16'd3, 16'd10, 1'b0, -1);
    run(16'hFFFF, 16'd1, 1'b0, -1);
    run(16'd100, 16'd7, 1'b0, 4);
    pulses = 0;
    repeat (20) begin @(negedge clk); if (done) pulses++; end
    chk("no_extra_done", pulses, 0);
    run(16'd100, 16'd7, 1'b0, 15);
    run(16'hFFFF, 16'hFFFF, 1'b0, -1);
    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    a = 16'd1000; b = 16'd3; sgn = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (30) begin @(negedge clk); if (done || busy) pulses++; end
    chk("no_done_after_abort", pulses, 0);
`ifdef DIV_SIGNED_EN
    run(16'hFFF9, 16'd2, 1'b1, -1);
    run(16'h8000, 16'hFFFF, 1'b1, -1);
    run(16'hFFF9, 16'd0, 1'b1, -1);
    run(16'd7, 16'hFFFE, 1'b1, -1);
`endif
    repeat (20) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom >> $urandom_range(0, 16));
`ifdef DIV_SIGNED_EN
      run(ra, rb, 1'($urandom), -1);
`else
      run(ra, rb, 1'b0, -1);
`endif
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle unsigned integer divider computing quotient and remainder by restoring shift-subtract, one quotient bit per clock. It replaces the 16-bit repeated-subtraction divider in the datapath: latency is fixed and independent of operand values, and the block adds a busy indication, divide-by-zero detection and an optional signed mode. It sits beside the accumulator datapath and is started by a single-cycle load strobe from the controller.

## Interface
- WIDTH, 16, operand, quotient and remainder width in bits; legal range is WIDTH >= 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  start request; sampled only in IDLE.
- a  in  WIDTH  dividend; captured on the accepted load edge.
- b  in  WIDTH  divisor; captured on the accepted load edge.
- sgn  in  1  signed-operation select; port exists only when DIV_SIGNED_EN is defined.
- q  out  WIDTH  quotient; holds its value until the next accepted load completes.
- r  out  WIDTH  remainder; same hold rule as q.
- busy  out  1  high from the edge after an accepted load until the result edge.
- done  out  1  single-cycle pulse marking a valid q/r.
- div_zero  out  1  set with done when the captured b == 0; cleared on the next accepted load.

## Operation
- Reset (rst low, asynchronous): state = IDLE; q, r, busy, done, div_zero = 0; internal registers = 0.
- States:
  - IDLE: load = 1 captures a and b. If b == 0, go to ZERO. Otherwise load the dividend shift register with a, clear the partial remainder, set count = 0, set busy = 1, go to RUN.
  - RUN: each edge shifts {rem, dvd} left by 1. If the shifted rem >= b, subtract b and shift in a quotient bit of 1; otherwise shift in 0. Increment count. When count == WIDTH-1, this edge is the last: write q and r, set done = 1, clear busy, go to IDLE.
  - ZERO: q = all ones, r = a, div_zero = 1, done = 1, go to IDLE.
- Partial remainder is WIDTH+1 bits so the compare/subtract cannot overflow. The counter is $clog2(WIDTH) bits wide, minimum 1.
- done is registered and lasts exactly one cycle. It falls on the next edge, including in the case where a new load is accepted on that edge.
- load while busy = 1 is ignored, with no queueing. A load on the same edge as the done pulse is not accepted; the controller reloads from IDLE on the next cycle.
- rst asserted mid-operation aborts immediately. No done pulse follows, and q/r return to 0.
- A quotient that does not fit is impossible in unsigned mode. For b == 1, q = a and r = 0.

## Timing
- Edge E0 accepts load; busy reads 1 after E0.
- Normal division: the RUN edges are E1..E_WIDTH. q, r and done are valid after E_WIDTH, so latency is WIDTH edges after the accept edge. The next load can be accepted at E_WIDTH+1.
- Divide by zero: q, r, done and div_zero are valid after E1. busy stays 0 throughout.
- Throughput: one division per WIDTH+1 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- DIV_SIGNED_EN
  - Defined: adds the sgn port. When sgn = 1 at the load edge, a and b are two's complement. The magnitudes are divided, and on the final edge the signs are fixed up:
    - the quotient is truncated toward zero and is negative if the operand signs differ;
    - the remainder takes the dividend's sign.
  - Signed overflow: most-negative / -1 yields q = most-negative and r = 0, with no flag.
  - Divide by zero in signed mode: q = all ones, r = a.
  - Latency is unchanged.
- Not defined: no sgn port; all operations are unsigned.

## Test plan
- WIDTH=16, a=100, b=7, load for 1 cycle -> busy for 16 cycles; done pulses after E16 with q=14, r=2, div_zero=0.
- a=5, b=0 -> after E1: done=1, div_zero=1, q=0xFFFF, r=5, busy never high. A following load a=9, b=3 clears div_zero and gives q=3, r=0.
- a=3, b=10 -> q=0, r=3. Then a=0xFFFF, b=1 -> q=0xFFFF, r=0. Both complete after E16.
- load pulsed again at E5 of a=100/b=7 with a=1, b=1 -> ignored; the result is still q=14, r=2, followed by exactly one done pulse.
- rst driven low at E8 of a running division -> q, r, busy and done read 0 immediately, and no done pulse appears afterwards.
- DIV_SIGNED_EN defined, sgn=1:
  - a=0xFFF9 (-7), b=2 -> q=0xFFFD (-3), r=0xFFFF (-1).
  - a=0x8000, b=0xFFFF -> q=0x8000, r=0.
